dm_cache_arbiter: RTL
=====================

Name: dm_cache_arbiter

Overview:
- Shares the single CPU-side port of the direct-mapped cache controller between two requesters: instruction fetch (port I) and load/store unit (port D).
- Sits between the core front/back end and the cache controller.
- Exchanges cpu_req_type / cpu_result_type from dm_cache_def on all three sides.
- One transaction in flight at a time; round-robin arbitration with a configurable tie-break.

Parameters:
- D_FIRST, 1, owner of the first grant after reset when both ports request (1 = D, 0 = I).
- PERF_CNT_W, 32, width of the performance counters (ARB_PERF_EN only).

Ports:
- clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- i_req  in  cpu_req_type  instruction-side request; rw must be 0.
- i_res  out  cpu_result_type  instruction-side result.
- d_req  in  cpu_req_type  data-side request.
- d_res  out  cpu_result_type  data-side result.
- cache_req  out  cpu_req_type  request to cache controller.
- cache_res  in  cpu_result_type  result from cache controller.
- i_rw_err  out  1  sticky: i_req.valid seen with rw=1 while IDLE.
- perf_i_grants  out  PERF_CNT_W  (ARB_PERF_EN only) I grants.
- perf_d_grants  out  PERF_CNT_W  (ARB_PERF_EN only) D grants.
- perf_conflicts  out  PERF_CNT_W  (ARB_PERF_EN only) IDLE cycles with both valid.

Behaviour:
- Reset: state=IDLE; owner=none; last_grant=I if D_FIRST=1, else D. All fields of cache_req, i_res and d_res = 0. i_rw_err=0. Counters=0.
- Reset mid-transaction: in-flight request abandoned; cache_req.valid drops asynchronously; no result forwarded.
- States: IDLE, BUSY, RESP.
- IDLE, no valid request: stay; outputs 0.
- IDLE, one valid request: grant it.
- IDLE, both valid: grant the port not equal to last_grant.
- On grant:
  - latch the request (addr, data, rw, valid) into a register;
  - owner <= port; last_grant <= port; -> BUSY.
  - cache_req is driven from the register, so the cycle after the requester's valid is sampled = 1-cycle issue latency.
- I request with rw=1: granted as a read (forced rw=0); i_rw_err set. Cleared only by rst.
- BUSY:
  - cache_req held constant with valid=1.
  - On cache_res.ready && cache_res.checked: latch cache_res into owner's result register (ready=1, checked=1, data, cache_index); cache_req.valid <= 0; -> RESP.
  - cache_res.ready without checked: ignored; stay BUSY.
- RESP:
  - owner's result ready/checked = 1 for exactly one cycle (1-cycle return latency).
  - Non-owner result ready stays 0.
  - -> IDLE; owner cleared; result ready/checked return to 0; data holds last value.
- Requester rules:
  - hold valid, addr, data, rw stable from assertion until its result ready is seen;
  - deassert valid on the edge ending that ready cycle, or keep it high to issue a new request.
  - A valid still high in IDLE is a new request.
- Minimum turnaround per transaction is 3 cycles beyond cache latency: grant, BUSY (≥1 cycle), RESP.
- A request arriving during BUSY/RESP waits; no queueing beyond the requester's held valid.
- Fairness: under continuous contention grants alternate strictly, so neither port waits more than one transaction.
- Result data is never forwarded to the non-owner.

Optional Feature:
- Macro ARB_PERF_EN.
- Defined:
  - perf_* ports and counters present.
  - Grant counters increment on each grant.
  - perf_conflicts increments on each IDLE cycle with both valid.
  - All counters saturate at all-ones (no wrap).
- Undefined: perf_* ports and logic absent; all other behaviour identical.

Decomposition:
- dm_cache_def gains:
  - arb_state_type enum {IDLE, BUSY, RESP};
  - arb_port_type enum {ARB_I, ARB_D};
  - cpu_req_type / cpu_result_type are reused unchanged.
- One natural sub-module: dm_cache_rr_pick, a combinational two-way round-robin picker (inputs: two valids, last_grant; outputs: grant, grant_port).
- The state machine and registers stay in dm_cache_arbiter.

Test Plan:
- Lone D read: d_req addr=0x0000_0040 rw=0 valid; cache returns data 0xDEAD_BEEF ready+checked 2 cycles after cache_req.valid. Expect:
  - cache_req.valid one cycle after d_req.valid;
  - d_res.ready=1, data=0xDEAD_BEEF for exactly 1 cycle;
  - i_res.ready=0 throughout.
- Simultaneous I (addr 0x100) and D (addr 0x200) after reset, D_FIRST=1, both held across 4 transactions. Expect:
  - cache_req.addr sequence 0x200, 0x100, 0x200, 0x100;
  - perf_conflicts ≥ 4 with ARB_PERF_EN.
- D write addr 0x80 data 0x1234_5678 rw=1. Expect cache_req.rw=1, cache_req.data=0x1234_5678, stable through BUSY.
- cache_res.ready=1, checked=0 for 3 cycles, then both 1 with data 0x55. Expect:
  - arbiter stays BUSY, no requester ready during the 3 cycles;
  - 0x55 forwarded once.
- I request rw=1 addr 0x44. Expect cache_req.rw=0 and i_rw_err=1 until reset.
- rst asserted in BUSY. Expect:
  - cache_req.valid=0, d_res.ready=0 immediately;
  - after release, next grant goes to the D_FIRST port and counters read 0.

Source files
------------

// File: rtl/dm_cache_def.sv
// Shared types for the direct-mapped cache and its CPU-side arbiter.
package dm_cache_def;

   localparam int CPU_ADDR_W    = 32;
   localparam int CPU_DATA_W    = 32;
   localparam int CACHE_INDEX_W = 10;

   // CPU-side request into the cache controller.
   typedef struct packed {
      logic [CPU_ADDR_W-1:0] addr;
      logic [CPU_DATA_W-1:0] data;
      logic                  rw;     // 1 = write
      logic                  valid;
   } cpu_req_type;

   // CPU-side result from the cache controller.
   typedef struct packed {
      logic [CPU_DATA_W-1:0]    data;
      logic [CACHE_INDEX_W-1:0] cache_index;
      logic                     ready;
      logic                     checked;
   } cpu_result_type;

   // Arbiter FSM states.
   typedef enum logic [1:0] {IDLE, BUSY, RESP} arb_state_type;

   // Requester identity.
   typedef enum logic {ARB_I, ARB_D} arb_port_type;

endpackage

// File: rtl/dm_cache_rr_pick.sv
// Combinational two-way round-robin picker: when both ports request, the
// port that did not win last time is chosen.
module dm_cache_rr_pick
   import dm_cache_def::*;
(
   input  logic         i_valid_i,
   input  logic         d_valid_i,
   input  arb_port_type last_grant_i,
   output logic         grant_o,
   output arb_port_type grant_port_o
);

   // Pick a winner among the valid ports, alternating under contention.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
      grant_o      = i_valid_i | d_valid_i;
      grant_port_o = ARB_I;
      if (i_valid_i && d_valid_i) begin
         grant_port_o = (last_grant_i == ARB_I) ? ARB_D : ARB_I;
      end else if (d_valid_i) begin
         grant_port_o = ARB_D;
      end
   end

endmodule

// File: rtl/dm_cache_arbiter.sv
// Shares the cache controller's single CPU port between instruction fetch (I)
// and load/store (D). One transaction in flight; round-robin arbitration.
// Optional performance counters are built when ARB_PERF_EN is defined.
module dm_cache_arbiter
   import dm_cache_def::*;
#(
   parameter bit D_FIRST = 1'b1
`ifdef ARB_PERF_EN
   , parameter int PERF_CNT_W = 32
`endif
)(
   input  logic           clk,
   input  logic           rst,
   input  cpu_req_type    i_req,
   output cpu_result_type i_res,
   input  cpu_req_type    d_req,
   output cpu_result_type d_res,
   output cpu_req_type    cache_req,
   input  cpu_result_type cache_res,
   output logic           i_rw_err
`ifdef ARB_PERF_EN
   , output logic [PERF_CNT_W-1:0] perf_i_grants
   , output logic [PERF_CNT_W-1:0] perf_d_grants
   , output logic [PERF_CNT_W-1:0] perf_conflicts
`endif
);

   // Reset value of last_grant makes the D_FIRST port win the first tie.
   localparam arb_port_type LAST_GRANT_RST = D_FIRST ? ARB_I : ARB_D;

   arb_state_type  state_q;
   arb_port_type   owner_q;      // meaningful only in BUSY/RESP
   arb_port_type   last_grant_q;
   cpu_req_type    req_q;
   cpu_result_type i_res_q;
   cpu_result_type d_res_q;
   logic           i_rw_err_q;

   logic           grant;
   arb_port_type   grant_port;
   cpu_req_type    req_d;

   dm_cache_rr_pick u_pick (
      .i_valid_i    (i_req.valid),
      .d_valid_i    (d_req.valid),
      .last_grant_i (last_grant_q),
      .grant_o      (grant),
      .grant_port_o (grant_port)
   );

   // Request to latch on grant; instruction fetch is always issued as a read.
   always_comb begin
      req_d = d_req;
      if (grant_port == ARB_I) begin
         req_d    = i_req;
         req_d.rw = 1'b0;
      end
      req_d.valid = 1'b1;
   end

   // Arbitration FSM with registered request and result outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         owner_q      <= ARB_I;
         last_grant_q <= LAST_GRANT_RST;
         req_q        <= '0;
         i_res_q      <= '0;
         d_res_q      <= '0;
         i_rw_err_q   <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
         case (state_q)
            IDLE: begin
               if (i_req.valid && i_req.rw) begin
                  i_rw_err_q <= 1'b1;
               end
               if (grant) begin
                  req_q        <= req_d;
                  owner_q      <= grant_port;
                  last_grant_q <= grant_port;
                  state_q      <= BUSY;
               end
            end
            BUSY: begin
               // A ready without checked is not a completed lookup; keep waiting.
               if (cache_res.ready && cache_res.checked) begin
                  if (owner_q == ARB_I) begin
                     i_res_q <= '{data: cache_res.data, cache_index: cache_res.cache_index,
                                  ready: 1'b1, checked: 1'b1};
                  end else begin
                     d_res_q <= '{data: cache_res.data, cache_index: cache_res.cache_index,
                                  ready: 1'b1, checked: 1'b1};
                  end
                  req_q   <= '0;
                  state_q <= RESP;
               end
            end
            RESP: begin
               // Result strobes last one cycle; data and index hold.
               i_res_q.ready   <= 1'b0;
               i_res_q.checked <= 1'b0;
               d_res_q.ready   <= 1'b0;
               d_res_q.checked <= 1'b0;
               owner_q         <= ARB_I;
               state_q         <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign cache_req = req_q;
   assign i_res     = i_res_q;
   assign d_res     = d_res_q;
   assign i_rw_err  = i_rw_err_q;

`ifdef ARB_PERF_EN
   logic [PERF_CNT_W-1:0] perf_i_q;
   logic [PERF_CNT_W-1:0] perf_d_q;
   logic [PERF_CNT_W-1:0] perf_c_q;

   // Saturating grant and contention counters.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_i_q <= '0;
         perf_d_q <= '0;
         perf_c_q <= '0;
      end else if (state_q == IDLE) begin
         if (grant && grant_port == ARB_I && perf_i_q != '1) perf_i_q <= perf_i_q + 1'b1;
         if (grant && grant_port == ARB_D && perf_d_q != '1) perf_d_q <= perf_d_q + 1'b1;
         if (i_req.valid && d_req.valid && perf_c_q != '1) perf_c_q <= perf_c_q + 1'b1;
      end
   end

   assign perf_i_grants  = perf_i_q;
   assign perf_d_grants  = perf_d_q;
   assign perf_conflicts = perf_c_q;
`endif

endmodule
